mem_stage_access_unit: RTL and testbench

//   Consumer end of the EX/MEM pipeline register. Takes the EX/MEM control and data fields, runs the

---
 rtl/mem_stage_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_stage_access_unit                                         |
// | Purpose  : MEM pipeline stage. Consumes the EX/MEM register, performs    |
// |            the data-memory access over a req/ack handshake of variable   |
// |            latency, stalls upstream while the access is outstanding,     |
// |            and produces the registered MEM/WB fields. Flags misaligned   |
// |            accesses and accesses that time out.                          |
// | Ports    :                                                               |
// |   clk, reset            clock, synchronous active-high reset             |
// |   ex_mem_*_i            EX/MEM control and data fields                   |
// |   dmem_req/we/addr/     data-memory request (held until ack)             |
// |   wdata_o                                                                |
// |   dmem_ack_i/rdata_i    data-memory completion, rdata valid with ack     |
// |   stall_o               combinational hold of EX/MEM and upstream        |
// |   align_err_o           1-cycle pulse, misaligned access dropped         |
// |   bus_err_o             1-cycle pulse, access timed out                  |
// |   mem_wb_*_o            registered MEM/WB fields                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_stage_access_unit #(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  // EX/MEM fields
  input  logic         ex_mem_mem_read_i,
  input  logic         ex_mem_mem_write_i,
  input  logic         ex_mem_reg_write_i,
  input  logic         ex_mem_mem_to_reg_i,
  input  logic [N-1:0] ex_mem_alu_result_i,
  input  logic [N-1:0] ex_mem_read_data2_i,
  input  logic [4:0]   ex_mem_write_reg_i,
  // data-memory interface
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [N-1:0] dmem_addr_o,
  output logic [N-1:0] dmem_wdata_o,
  input  logic         dmem_ack_i,
  input  logic [N-1:0] dmem_rdata_i,
  // pipeline control and errors
  output logic         stall_o,
  output logic         align_err_o,
  output logic         bus_err_o,
  // MEM/WB fields
  output logic         mem_wb_reg_write_o,
  output logic         mem_wb_mem_to_reg_o,
  output logic [N-1:0] mem_wb_read_data_o,
  output logic [N-1:0] mem_wb_alu_result_o,
  output logic [4:0]   mem_wb_write_reg_o
);

  // Counter wide enough to hold TIMEOUT; the timeout fires on its last value.
  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic          r_req;
  logic          r_we;
  logic [N-1:0]  r_addr;
  logic [N-1:0]  r_wdata;
  logic          r_align_err;
  logic          r_bus_err;
  logic          r_wb_reg_write;
  logic          r_wb_mem_to_reg;
  logic [N-1:0]  r_wb_read_data;
  logic [N-1:0]  r_wb_alu_result;
  logic [4:0]    r_wb_write_reg;

  logic          w_in_idle;
  logic          w_in_access;
  logic          w_access;
  logic          w_aligned;
  logic          w_issue;
  logic          w_misalign;
  logic          w_ack;
  logic          w_timeout;
  logic          w_wb_load;
  logic [N-1:0]  w_wb_rdata;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_access = (r_state == S_ACCESS);

  // A request with both read and write set is treated as a write.
  assign w_access    = ex_mem_mem_read_i | ex_mem_mem_write_i;
  assign w_aligned   = (ex_mem_alu_result_i[1:0] == 2'b00);
  assign w_issue     = w_in_idle & w_access & w_aligned;
  assign w_misalign  = w_in_idle & w_access & ~w_aligned;

  // Ack takes priority over an expiring counter in the same cycle.
  assign w_ack       = w_in_access & dmem_ack_i;
  assign w_timeout   = w_in_access & ~dmem_ack_i & (r_cnt == C_CNT_LAST);

  // Stall is released in the completion cycle so EX/MEM advances on the
  // same edge that MEM/WB captures the result.
  assign stall_o     = w_issue | (w_in_access & ~w_ack & ~w_timeout);

  // MEM/WB takes the real EX/MEM fields for non-memory instructions and on
  // a completed access; every other cycle it takes a bubble.
  assign w_wb_load   = (w_in_idle & ~w_access) | w_ack;
  assign w_wb_rdata  = (w_ack & ~r_we) ? dmem_rdata_i : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_req           <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_align_err     <= 1'b0;
      r_bus_err       <= 1'b0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_read_data  <= '0;
      r_wb_alu_result <= '0;
      r_wb_write_reg  <= '0;
    end else begin
      r_align_err <= w_misalign;
      r_bus_err   <= w_timeout;

      if (w_wb_load) begin
        r_wb_reg_write  <= ex_mem_reg_write_i;
        r_wb_mem_to_reg <= ex_mem_mem_to_reg_i;
        r_wb_read_data  <= w_wb_rdata;
        r_wb_alu_result <= ex_mem_alu_result_i;
        r_wb_write_reg  <= ex_mem_write_reg_i;
      end else begin
        r_wb_reg_write  <= 1'b0;
        r_wb_mem_to_reg <= 1'b0;
        r_wb_read_data  <= '0;
        r_wb_alu_result <= '0;
        r_wb_write_reg  <= '0;
      end

      case (r_state)
        S_IDLE: begin
          // Late acks arriving here are simply not looked at.
          if (w_issue) begin
            r_state <= S_ACCESS;
            r_cnt   <= '0;
            r_req   <= 1'b1;
            r_we    <= ex_mem_mem_write_i;
            r_addr  <= ex_mem_alu_result_i;
            r_wdata <= ex_mem_read_data2_i;
          end
        end
        S_ACCESS: begin
          // Address/data stay in r_addr/r_wdata; EX/MEM is not re-sampled.
          if (w_ack || w_timeout) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign dmem_req_o          = r_req;
  assign dmem_we_o           = r_we;
  assign dmem_addr_o         = r_addr;
  assign dmem_wdata_o        = r_wdata;
  assign align_err_o         = r_align_err;
  assign bus_err_o           = r_bus_err;
  assign mem_wb_reg_write_o  = r_wb_reg_write;
  assign mem_wb_mem_to_reg_o = r_wb_mem_to_reg;
  assign mem_wb_read_data_o  = r_wb_read_data;
  assign mem_wb_alu_result_o = r_wb_alu_result;
  assign mem_wb_write_reg_o  = r_wb_write_reg;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_stage_access_unit                                      |
// | Purpose  : Directed bench for mem_stage_access_unit. Stimulus pushes     |
// |            expected MEM/WB results and error pulses into a scoreboard;   |
// |            a monitor pops and compares whenever the DUT presents one.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_stage_access_unit;

  localparam int N       = 32;
  localparam int TIMEOUT = 16;

  localparam int K_WB    = 0;
  localparam int K_ALIGN = 1;
  localparam int K_BUS   = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_mem_mem_read_i;
  logic         ex_mem_mem_write_i;
  logic         ex_mem_reg_write_i;
  logic         ex_mem_mem_to_reg_i;
  logic [N-1:0] ex_mem_alu_result_i;
  logic [N-1:0] ex_mem_read_data2_i;
  logic [4:0]   ex_mem_write_reg_i;
  logic         dmem_req_o;
  logic         dmem_we_o;
  logic [N-1:0] dmem_addr_o;
  logic [N-1:0] dmem_wdata_o;
  logic         dmem_ack_i;
  logic [N-1:0] dmem_rdata_i;
  logic         stall_o;
  logic         align_err_o;
  logic         bus_err_o;
  logic         mem_wb_reg_write_o;
  logic         mem_wb_mem_to_reg_o;
  logic [N-1:0] mem_wb_read_data_o;
  logic [N-1:0] mem_wb_alu_result_o;
  logic [4:0]   mem_wb_write_reg_o;

  mem_stage_access_unit #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ex_mem_mem_read_i   (ex_mem_mem_read_i),
    .ex_mem_mem_write_i  (ex_mem_mem_write_i),
    .ex_mem_reg_write_i  (ex_mem_reg_write_i),
    .ex_mem_mem_to_reg_i (ex_mem_mem_to_reg_i),
    .ex_mem_alu_result_i (ex_mem_alu_result_i),
    .ex_mem_read_data2_i (ex_mem_read_data2_i),
    .ex_mem_write_reg_i  (ex_mem_write_reg_i),
    .dmem_req_o          (dmem_req_o),
    .dmem_we_o           (dmem_we_o),
    .dmem_addr_o         (dmem_addr_o),
    .dmem_wdata_o        (dmem_wdata_o),
    .dmem_ack_i          (dmem_ack_i),
    .dmem_rdata_i        (dmem_rdata_i),
    .stall_o             (stall_o),
    .align_err_o         (align_err_o),
    .bus_err_o           (bus_err_o),
    .mem_wb_reg_write_o  (mem_wb_reg_write_o),
    .mem_wb_mem_to_reg_o (mem_wb_mem_to_reg_o),
    .mem_wb_read_data_o  (mem_wb_read_data_o),
    .mem_wb_alu_result_o (mem_wb_alu_result_o),
    .mem_wb_write_reg_o  (mem_wb_write_reg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic rw, input logic m2r,
                      input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] rd);
    exp_t e;
    e.kind = kind; e.rw = rw; e.m2r = m2r; e.rdata = rdata; e.alu = alu; e.rd = rd;
    sb.push_back(e);
  endtask

  // Monitor: a nonzero MEM/WB or an error pulse is an observed event.
  task automatic observe(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event_kind", 64'(kind), 64'hFFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 64'(kind), 64'(e.kind));
      if (kind == K_WB && e.kind == K_WB) begin
        chk("wb_reg_write", 64'(mem_wb_reg_write_o),  64'(e.rw));
        chk("wb_mem_to_reg", 64'(mem_wb_mem_to_reg_o), 64'(e.m2r));
        chk("wb_read_data", 64'(mem_wb_read_data_o),  64'(e.rdata));
        chk("wb_alu_result", 64'(mem_wb_alu_result_o), 64'(e.alu));
        chk("wb_write_reg", 64'(mem_wb_write_reg_o),  64'(e.rd));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (align_err_o) observe(K_ALIGN);
      if (bus_err_o)   observe(K_BUS);
      if (mem_wb_reg_write_o || mem_wb_mem_to_reg_o || (mem_wb_read_data_o != '0) ||
          (mem_wb_alu_result_o != '0) || (mem_wb_write_reg_o != '0))
        observe(K_WB);
    end
  end

  task automatic set_exmem(input logic rd_, input logic wr_, input logic rw, input logic m2r,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    ex_mem_mem_read_i   = rd_;
    ex_mem_mem_write_i  = wr_;
    ex_mem_reg_write_i  = rw;
    ex_mem_mem_to_reg_i = m2r;
    ex_mem_alu_result_i = alu;
    ex_mem_read_data2_i = wd;
    ex_mem_write_reg_i  = rd;
  endtask

  task automatic clr_exmem();
    set_exmem(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   64'(dmem_req_o), 64'h0);
    chk({tag, "_we"},    64'(dmem_we_o), 64'h0);
    chk({tag, "_addr"},  64'(dmem_addr_o), 64'h0);
    chk({tag, "_wdata"}, 64'(dmem_wdata_o), 64'h0);
    chk({tag, "_stall"}, 64'(stall_o), 64'h0);
    chk({tag, "_errs"},  64'({align_err_o, bus_err_o}), 64'h0);
    chk({tag, "_wb"},    64'({mem_wb_reg_write_o, mem_wb_mem_to_reg_o, mem_wb_write_reg_o}), 64'h0);
    chk({tag, "_wb_data"}, {mem_wb_read_data_o, mem_wb_alu_result_o}, 64'h0);
  endtask

  // Called just after a posedge. Drives one memory instruction and plays the
  // memory side: ack is raised on req cycle number ack_after (0-based), or
  // never when ack_after < 0. Returns after the completion edge with the
  // inputs cleared, at the negedge of the following IDLE cycle.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic rw, input logic m2r, input logic [4:0] rd,
                            input int ack_after, input logic [31:0] rdata,
                            output int stalls, output int reqs, output int cycles);
    bit done = 0;
    stalls = 0; reqs = 0; cycles = 0;
    set_exmem(~wr, wr, rw, m2r, addr, wd, rd);
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      dmem_ack_i   = dmem_req_o && (reqs == ack_after);
      dmem_rdata_i = dmem_ack_i ? rdata : 32'h5A5A_0F0F;
      @(negedge clk);
      cycles++;
      if (dmem_req_o) begin
        reqs++;
        chk("req_we",    64'(dmem_we_o), 64'(wr));
        chk("req_addr",  64'(dmem_addr_o), 64'(addr));
        chk("req_wdata", 64'(dmem_wdata_o), 64'(wd));
      end
      if (stall_o) stalls++;
      else done = 1;
    end
    if (!done) chk("access_bound_expired", 64'h0, 64'h1);
    @(posedge clk); #1;
    clr_exmem();
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    chk("req_low_after", 64'(dmem_req_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rq, cy;
    reset        = 1'b1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    clr_exmem();
    @(negedge clk);
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // 1. ALU op: one-cycle pass-through, no stall.
    @(posedge clk); #1;
    set_exmem(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    push(K_WB, 1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
    @(negedge clk);
    chk("alu_stall", 64'(stall_o), 64'h0);
    @(posedge clk); #1;
    clr_exmem();
    @(negedge clk);
    chk("alu_stall_after", 64'(stall_o), 64'h0);

    // 2. Load 0x40, ack on the 4th req cycle.
    @(posedge clk); #1;
    push(K_WB, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 5'd7);
    run_access(1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 5'd7, 3, 32'hDEAD_BEEF, st, rq, cy);
    chk("load_stall_cycles", 64'(st), 64'd4);
    chk("load_req_cycles", 64'(rq), 64'd4);

    // 3. Store 0x44, ack on the first req cycle: 2-cycle access.
    @(posedge clk); #1;
    push(K_WB, 1'b0, 1'b0, 32'h0, 32'h0000_0044, 5'd0);
    run_access(1'b1, 32'h44, 32'hA5A5_A5A5, 1'b0, 1'b0, 5'd0, 0, 32'h1234_5678, st, rq, cy);
    chk("store_latency", 64'(cy), 64'd2);
    chk("store_stall_cycles", 64'(st), 64'd1);
    chk("store_req_cycles", 64'(rq), 64'd1);

    // 4. Load never acked: timeout after TIMEOUT req cycles.
    @(posedge clk); #1;
    push(K_BUS, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    run_access(1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 5'd9, -1, 32'h0, st, rq, cy);
    chk("timeout_req_cycles", 64'(rq), 64'(TIMEOUT));
    chk("timeout_stall_cycles", 64'(st), 64'(TIMEOUT));

    // 5. Misaligned load 0x42: dropped with align_err.
    @(posedge clk); #1;
    push(K_ALIGN, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    run_access(1'b0, 32'h42, 32'h0, 1'b1, 1'b1, 5'd4, 0, 32'h0, st, rq, cy);
    chk("misalign_req_cycles", 64'(rq), 64'd0);
    chk("misalign_stall_cycles", 64'(st), 64'd0);

    // 6. Reset mid-access, late ack ignored, then a normal load.
    @(posedge clk); #1;
    set_exmem(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    clr_exmem();
    @(negedge clk);
    chk("pre_reset_req", 64'(dmem_req_o), 64'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset        = 1'b0;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'hBAAD_F00D;
    @(negedge clk);
    chk("late_ack_stall", 64'(stall_o), 64'h0);
    @(posedge clk); #1;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    chk_all_zero("late_ack");
    @(posedge clk); #1;
    push(K_WB, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_0048, 5'd12);
    run_access(1'b0, 32'h48, 32'h0, 1'b1, 1'b1, 5'd12, 1, 32'hCAFE_F00D, st, rq, cy);
    chk("reload_stall_cycles", 64'(st), 64'd2);
    chk("reload_req_cycles", 64'(rq), 64'd2);

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
